periph_bus_initiator: RTL and testbench

Bus initiator that converts single load/store requests from the core (byte address, size, sign) into accesses on the team's memory-mapped peripheral bus (`address`, `byte_en`, `data`, `rw`, `clken`, `q`). It sits between the core's load/store path and the peripheral bank (GPIO and similar slaves). It generates byte enables and lane-replicated write data, issues a single-cycle `clken` strobe, waits the fixed peripheral read latency, and returns aligned, extended read data.

---
 rtl/periph_bus_pkg.sv | 18 +
 rtl/periph_bus_initiator_if.sv | 35 +++
 rtl/periph_lane_align.sv | 36 +++
 rtl/periph_bus_initiator.sv | 114 +++++++++++
 tb/tb_periph_bus_initiator.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared encodings for the peripheral bus initiator
package periph_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/periph_bus_initiator_if.sv
// periph_bus_initiator_if: core request/response and peripheral bus signals
interface periph_bus_initiator_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] bus_address;
    logic [3:0]        bus_byte_en;
    logic [31:0]       bus_data;
    logic              bus_rw;
    logic              bus_clken;
    logic [31:0]       bus_q;

    // initiator side
    modport master (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, bus_q,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               bus_address, bus_byte_en, bus_data, bus_rw, bus_clken
    );

    // core and peripheral side
    modport slave (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, bus_q,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               bus_address, bus_byte_en, bus_data, bus_rw, bus_clken
    );
endinterface

// File: rtl/periph_lane_align.sv
// periph_lane_align: byte enables, write lane replication, alignment check, read extraction
module periph_lane_align
    import periph_bus_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    input  logic [1:0]  i_rd_lo,
    input  logic [1:0]  i_rd_size,
    input  logic        i_rd_unsigned,
    input  logic [31:0] i_q,
    output logic [31:0] o_rdata
);
    logic [7:0]  w_b;
    logic [15:0] w_h;

    assign o_misaligned = (i_size == SZ_HALF && i_addr_lo[0]) ||
                          (i_size == SZ_WORD && i_addr_lo != 2'b00) ||
                          (i_size == 2'b11);

    assign o_byte_en = i_size == SZ_BYTE ? 4'b0001 << i_addr_lo :
                       i_size == SZ_HALF ? 4'b0011 << i_addr_lo : 4'b1111;

    // replicate so peripherals reading either the addressed lane or the low lane see the data
    assign o_wdata = i_size == SZ_BYTE ? {4{i_wdata[7:0]}} :
                     i_size == SZ_HALF ? {2{i_wdata[15:0]}} : i_wdata;

    assign w_b = 8'(i_q >> {i_rd_lo, 3'b000});
    assign w_h = i_rd_lo[1] ? i_q[31:16] : i_q[15:0];

    assign o_rdata = i_rd_size == SZ_BYTE ? {{24{w_b[7] & ~i_rd_unsigned}}, w_b} :
                     i_rd_size == SZ_HALF ? {{16{w_h[15] & ~i_rd_unsigned}}, w_h} : i_q;
endmodule

// File: rtl/periph_bus_initiator.sv
// periph_bus_initiator: single load/store requests to strobed peripheral bus accesses
module periph_bus_initiator
    import periph_bus_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input logic                   clk,
    input logic                   nreset,
    periph_bus_initiator_if.master bus
);
    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_cnt;
    logic              r_ready;
    logic              r_we;
    logic              r_uns;
    logic              r_err;
    logic [1:0]        r_lo;
    logic [1:0]        r_size;
    logic [31:0]       r_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_data;
    logic              r_rw;
    logic              w_accept;
    logic              w_bad;
    logic              w_issue;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_unused = &{1'b0, bus.req_addr};
    assign w_accept = bus.req_valid & r_ready;
    assign w_issue  = w_accept & ~w_bad;

    periph_lane_align u_align (
        .i_addr_lo    (bus.req_addr[1:0]),
        .i_size       (bus.req_size),
        .i_wdata      (bus.req_wdata),
        .o_byte_en    (w_be),
        .o_wdata      (w_wdata),
        .o_misaligned (w_bad),
        .i_rd_lo      (r_lo),
        .i_rd_size    (r_size),
        .i_rd_unsigned(r_uns),
        .i_q          (bus.bus_q),
        .o_rdata      (w_rdata)
    );

    // next-state: errors skip the bus and respond straight away
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (w_bad ? RESP : ISSUE) : IDLE;
            ISSUE:   w_next = r_we ? RESP : WAIT;
            WAIT:    w_next = r_cnt == 3'd1 ? RESP : WAIT;
            default: w_next = IDLE;
        endcase
    end

    // state, latched request, latency counter and registered bus outputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_lo    <= '0;
            r_size  <= '0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_be    <= '0;
            r_data  <= '0;
            r_rw    <= RW_READ;
        end else begin
            r_state <= w_next;
            r_ready <= w_next == IDLE;
            r_rw    <= w_issue && bus.req_we ? RW_WRITE : RW_READ;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_uns   <= bus.req_unsigned;
                r_err   <= w_bad;
                r_lo    <= bus.req_addr[1:0];
                r_size  <= bus.req_size;
                r_rdata <= '0;
            end
            if (w_issue) begin
                r_addr <= bus.req_addr[ADDR_W+1:2];
                r_be   <= w_be;
                r_data <= w_wdata;
            end
            if (r_state == ISSUE)
                r_cnt <= 3'(RD_LAT);
            else if (r_state == WAIT)
                r_cnt <= r_cnt - 3'd1;
            if (r_state == WAIT && r_cnt == 3'd1)
                r_rdata <= w_rdata;
        end
    end

    assign bus.req_ready   = r_ready;
    assign bus.rsp_valid   = r_state == RESP;
    assign bus.rsp_rdata   = r_rdata;
    assign bus.rsp_err     = r_err;
    assign bus.bus_address = r_addr;
    assign bus.bus_byte_en = r_be;
    assign bus.bus_data    = r_data;
    assign bus.bus_rw      = r_rw;
    assign bus.bus_clken   = r_state == ISSUE;
endmodule

// File: tb/tb_periph_bus_initiator.sv
// tb_periph_bus_initiator: directed checks of the peripheral bus initiator at RD_LAT 1 and 3
module tb_periph_bus_initiator;
    import periph_bus_pkg::*;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        sel, valid, we, uns;
    logic [31:0] addr, wd, pq;
    logic [1:0]  size;
    int          c1 = 0, c3 = 0;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    periph_bus_initiator_if #(.ADDR_W(8)) bif();
    periph_bus_initiator_if #(.ADDR_W(8)) bif3();

    periph_bus_initiator #(.ADDR_W(8), .RD_LAT(1)) dut (.clk(clk), .nreset(nreset), .bus(bif.master));
    periph_bus_initiator #(.ADDR_W(8), .RD_LAT(3)) dut3 (.clk(clk), .nreset(nreset), .bus(bif3.master));

    assign bif.req_valid     = valid & ~sel;
    assign bif3.req_valid    = valid & sel;
    assign bif.req_addr      = addr;
    assign bif3.req_addr     = addr;
    assign bif.req_we        = we;
    assign bif3.req_we       = we;
    assign bif.req_size      = size;
    assign bif3.req_size     = size;
    assign bif.req_unsigned  = uns;
    assign bif3.req_unsigned = uns;
    assign bif.req_wdata     = wd;
    assign bif3.req_wdata    = wd;

    // peripheral model: read data valid only in the cycle ending at the capture edge
    always @(posedge clk) begin
        c1 <= (bif.bus_clken && bif.bus_rw) ? 1 : (c1 > 0 ? c1 - 1 : 0);
        c3 <= (bif3.bus_clken && bif3.bus_rw) ? 3 : (c3 > 0 ? c3 - 1 : 0);
    end
    assign bif.bus_q  = c1 == 1 ? pq : 32'h5555_5555;
    assign bif3.bus_q = c3 == 1 ? pq : 32'h5555_5555;

    wire        m_ready = sel ? bif3.req_ready   : bif.req_ready;
    wire        m_rv    = sel ? bif3.rsp_valid   : bif.rsp_valid;
    wire [31:0] m_rd    = sel ? bif3.rsp_rdata   : bif.rsp_rdata;
    wire        m_err   = sel ? bif3.rsp_err     : bif.rsp_err;
    wire [7:0]  m_ba    = sel ? bif3.bus_address : bif.bus_address;
    wire [3:0]  m_be    = sel ? bif3.bus_byte_en : bif.bus_byte_en;
    wire [31:0] m_bd    = sel ? bif3.bus_data    : bif.bus_data;
    wire        m_rw    = sel ? bif3.bus_rw      : bif.bus_rw;
    wire        m_ck    = sel ? bif3.bus_clken   : bif.bus_clken;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xact(input logic a_we, input logic [31:0] a_addr, input logic [1:0] a_size,
                        input logic a_uns, input logic [31:0] a_wd, input logic [7:0] e_ba,
                        input logic [3:0] e_be, input logic [31:0] e_bd, input logic [31:0] e_rd,
                        input logic e_err, input int e_lat);
        int cyc = 1;
        int ck_n = 0;
        int got = 0;
        check("ready_pre", m_ready, 1);
        we = a_we; addr = a_addr; size = a_size; uns = a_uns; wd = a_wd; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        while (cyc <= 12 && got == 0) begin
            if (m_ck) begin
                ck_n++;
                check("bus_address", m_ba, e_ba);
                check("bus_byte_en", m_be, e_be);
                check("bus_rw", m_rw, !a_we);
                if (a_we) check("bus_data", m_bd, e_bd);
            end
            if (m_rv) begin
                got = cyc;
                check("rsp_rdata", m_rd, e_rd);
                check("rsp_err", m_err, e_err);
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("rsp_latency", got, e_lat);
        check("clken_pulses", ck_n, e_err ? 0 : 1);
        @(posedge clk); #1;
        check("ready_post", m_ready, 1);
        check("rsp_valid_post", m_rv, 0);
        check("rw_idle", m_rw, 1);
    endtask

    task automatic release_reset();
        @(negedge clk);
        nreset = 1'b1;
        #1;
        check("ready_before_edge", m_ready, 0);
        @(posedge clk); #1;
        check("ready_after_edge", m_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[3];
        int n_acc, n_ck, n_rv;
        sel = 1'b0; valid = 1'b0; we = 1'b0; uns = 1'b0; addr = '0; wd = '0; size = '0; pq = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", m_ready, 0);
        check("rst_rsp_valid", m_rv, 0);
        check("rst_rdata", m_rd, 0);
        check("rst_err", m_err, 0);
        check("rst_address", m_ba, 0);
        check("rst_byte_en", m_be, 0);
        check("rst_data", m_bd, 0);
        check("rst_rw", m_rw, 1);
        check("rst_clken", m_ck, 0);
        release_reset();

        xact(1'b1, 32'h04, SZ_WORD, 1'b0, 32'hDEADBEEF, 8'd1, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        xact(1'b1, 32'h01, SZ_BYTE, 1'b0, 32'h0000005A, 8'd0, 4'b0010, 32'h5A5A5A5A, 32'h0, 1'b0, 2);
        xact(1'b1, 32'h02, SZ_HALF, 1'b0, 32'h0000BEEF, 8'd0, 4'b1100, 32'hBEEFBEEF, 32'h0, 1'b0, 2);
        xact(1'b1, 32'h0B, SZ_BYTE, 1'b0, 32'h000000C3, 8'd2, 4'b1000, 32'hC3C3C3C3, 32'h0, 1'b0, 2);
        pq = 32'h000080FF;
        xact(1'b0, 32'h05, SZ_BYTE, 1'b0, 32'h0, 8'd1, 4'b0010, 32'h0, 32'hFFFFFF80, 1'b0, 3);
        xact(1'b0, 32'h05, SZ_BYTE, 1'b1, 32'h0, 8'd1, 4'b0010, 32'h0, 32'h00000080, 1'b0, 3);
        pq = 32'h80011234;
        xact(1'b0, 32'h06, SZ_HALF, 1'b0, 32'h0, 8'd1, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0, 3);
        xact(1'b0, 32'h04, SZ_HALF, 1'b0, 32'h0, 8'd1, 4'b0011, 32'h0, 32'h00001234, 1'b0, 3);
        xact(1'b0, 32'h08, SZ_WORD, 1'b0, 32'h0, 8'd2, 4'b1111, 32'h0, 32'h80011234, 1'b0, 3);
        xact(1'b1, 32'h02, SZ_WORD, 1'b0, 32'h11111111, 8'd0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
        xact(1'b0, 32'h03, SZ_HALF, 1'b0, 32'h0, 8'd0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);
        xact(1'b0, 32'h00, 2'b11, 1'b0, 32'h0, 8'd0, 4'b0000, 32'h0, 32'h0, 1'b1, 1);

        we = 1'b1; addr = 32'h10; size = SZ_WORD; wd = 32'h01234567; valid = 1'b1;
        n_acc = 0; n_ck = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (m_ready && n_acc < 3) begin acc[n_acc] = i; n_acc++; end
            if (m_ck) n_ck++;
        end
        valid = 1'b0;
        @(posedge clk); #1;
        check("tp_accepts", n_acc, 3);
        check("tp_clken", n_ck, 3);
        check("tp_gap1", acc[1] - acc[0], 3);
        check("tp_gap2", acc[2] - acc[1], 3);
        @(posedge clk); #1;

        sel = 1'b1;
        pq = 32'h000080FF;
        xact(1'b0, 32'h05, SZ_BYTE, 1'b0, 32'h0, 8'd1, 4'b0010, 32'h0, 32'hFFFFFF80, 1'b0, 5);

        we = 1'b0; addr = 32'h05; size = SZ_BYTE; uns = 1'b0; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b0;
        #1;
        check("rstwait_clken", m_ck, 0);
        check("rstwait_rsp_valid", m_rv, 0);
        check("rstwait_ready", m_ready, 0);
        release_reset();
        n_rv = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bif.rsp_valid || bif3.rsp_valid) n_rv++;
        end
        check("no_stale_rsp", n_rv, 0);

        sel = 1'b0;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        check("rstissue_clken_pre", m_ck, 1);
        nreset = 1'b0;
        #1;
        check("rstissue_clken", m_ck, 0);
        release_reset();

        we = 1'b1; addr = 32'h01; size = SZ_WORD; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        check("rstresp_rsp_pre", m_rv, 1);
        nreset = 1'b0;
        #1;
        check("rstresp_rsp_valid", m_rv, 0);
        release_reset();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
